// File: rtl/rect_block_sequencer_pkg.sv
// Shared sizing and state encoding for the RECTANGLE block sequencer and its round counter.
package rect_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 25;
  localparam int CNT_W      = $clog2(NUM_ROUNDS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    OUT
  } state_e;

endpackage

// File: rtl/rect_block_sequencer_if.sv
// Input stream, core drive/sample and output stream of the RECTANGLE sequencer.
// With RECT_CBC_EN defined the bundle also carries the iv_load/iv chaining inputs.
interface rect_block_sequencer_if;
  import rect_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [BLOCK_W-1:0] s_text;
  logic [KEY_W-1:0]   s_key;
  logic               s_ed;

  logic               core_start;
  logic [BLOCK_W-1:0] core_text;
  logic [KEY_W-1:0]   core_key;
  logic               core_ed;
  logic [BLOCK_W-1:0] core_result;

  logic               m_valid;
  logic               m_ready;
  logic [BLOCK_W-1:0] m_text;

`ifdef RECT_CBC_EN
  logic               iv_load;
  logic [BLOCK_W-1:0] iv;

  modport master (
    input  s_valid, s_text, s_key, s_ed, core_result, m_ready, iv_load, iv,
    output s_ready, core_start, core_text, core_key, core_ed, m_valid, m_text
  );

  modport slave (
    output s_valid, s_text, s_key, s_ed, core_result, m_ready, iv_load, iv,
    input  s_ready, core_start, core_text, core_key, core_ed, m_valid, m_text
  );
`else
  modport master (
    input  s_valid, s_text, s_key, s_ed, core_result, m_ready,
    output s_ready, core_start, core_text, core_key, core_ed, m_valid, m_text
  );

  modport slave (
    output s_valid, s_text, s_key, s_ed, core_result, m_ready,
    input  s_ready, core_start, core_text, core_key, core_ed, m_valid, m_text
  );
`endif

endinterface

// File: rtl/rect_round_counter.sv
// Round counter for the sequencer: cleared when a block is launched, counts while the core runs,
// flags the last round. Never wraps because it is cleared before every block.
module rect_round_counter
  import rect_pkg::*;
(
  input  logic clk,
  input  logic R,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == CNT_W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/rect_block_sequencer.sv
// Valid/ready sequencer around the iterative RECTANGLE core: one block in flight, result held until taken.
// Optional CBC chaining is compiled in when RECT_CBC_EN is defined.
module rect_block_sequencer
  import rect_pkg::*;
(
  input  logic                   clk,
  input  logic                   R,
  rect_block_sequencer_if.master bus,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] text_q, text_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               ed_q, ed_d;
  logic [BLOCK_W-1:0] m_text_q, m_text_d;
`ifdef RECT_CBC_EN
  logic [BLOCK_W-1:0] chain_q, chain_d;
`endif

  logic s_ready_c;
  logic core_start_c;
  logic m_valid_c;
  logic accept;
  logic capture;
  logic cnt_clear;
  logic cnt_en;
  logic cnt_done;

  rect_round_counter u_round_counter (
    .clk     (clk),
    .R       (R),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .done_o  (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    s_ready_c    = 1'b0;
    core_start_c = 1'b0;
    m_valid_c    = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef RECT_CBC_EN
        s_ready_c = !bus.iv_load;
`else
        s_ready_c = 1'b1;
`endif
        if (bus.s_valid && s_ready_c) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        core_start_c = 1'b1;
        cnt_clear    = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        m_valid_c = 1'b1;
        // Ready follows the consumer so a new block can enter on the same handshake edge.
        s_ready_c = bus.m_ready;
        if (bus.m_ready) begin
          if (bus.s_valid) begin
            accept  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    key_d    = key_q;
    ed_d     = ed_q;
    text_d   = text_q;
    m_text_d = m_text_q;
`ifdef RECT_CBC_EN
    chain_d  = chain_q;
    if (state_q == IDLE && bus.iv_load) begin
      chain_d = bus.iv;
    end
    if (accept) begin
      text_d = bus.s_ed ? (bus.s_text ^ chain_q) : bus.s_text;
    end
    // Decrypt keeps the untouched ciphertext in text_q, which becomes the next chain value.
    if (capture) begin
      if (ed_q) begin
        m_text_d = bus.core_result;
        chain_d  = bus.core_result;
      end else begin
        m_text_d = bus.core_result ^ chain_q;
        chain_d  = text_q;
      end
    end
`else
    if (accept) begin
      text_d = bus.s_text;
    end
    if (capture) begin
      m_text_d = bus.core_result;
    end
`endif
    if (accept) begin
      key_d = bus.s_key;
      ed_d  = bus.s_ed;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q  <= IDLE;
      text_q   <= '0;
      key_q    <= '0;
      ed_q     <= 1'b0;
      m_text_q <= '0;
`ifdef RECT_CBC_EN
      chain_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      text_q   <= text_d;
      key_q    <= key_d;
      ed_q     <= ed_d;
      m_text_q <= m_text_d;
`ifdef RECT_CBC_EN
      chain_q  <= chain_d;
`endif
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.core_start = core_start_c;
  assign bus.core_text  = text_q;
  assign bus.core_key   = key_q;
  assign bus.core_ed    = ed_q;
  assign bus.m_valid    = m_valid_c;
  assign bus.m_text     = m_text_q;
  assign busy           = (state_q != IDLE);

endmodule
